// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation block:
// FSM state encoding, default operand width and latency helper.
package rsa_pkg;

   localparam int unsigned DEFAULT_WORD_WIDTH = 32;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t LOAD   = 3'd1;
   localparam state_t MULT   = 3'd2;
   localparam state_t UPDATE = 3'd3;
   localparam state_t FINISH = 3'd4;

   // Cycles from the edge that samples start to the edge that raises done.
   function automatic int unsigned modexp_latency(input int unsigned w);
      return w * (w + 1) + 2;
   endfunction

   // Width of a counter that walks 0 .. w-1 (at least one bit).
   function automatic int unsigned ctr_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mod_mult.sv
// Bit-serial modular multiplier: result = a*b mod n in WORD_WIDTH cycles.
// Interleaved MSB-first shift-add, r = 2r + a_i*b, then up to two
// conditional subtractions of n. Requires b < n.
// The first step runs on the start edge, so done is visible WORD_WIDTH
// cycles after start is asserted and stays high until the next start.
module mod_mult
   import rsa_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic [WORD_WIDTH-1:0] n,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] result
);

   localparam int unsigned CW = ctr_width(WORD_WIDTH);
   localparam int unsigned XW = WORD_WIDTH + 2;

   logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, r_q, r_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  busy_q, busy_d, done_q, done_d;

   // One interleaved step; 2r + b < 3n < 2^(WORD_WIDTH+2), so XW bits never overflow.
   function automatic logic [WORD_WIDTH-1:0] step(input logic [WORD_WIDTH-1:0] r,
                                                  input logic                  bit_i,
                                                  input logic [WORD_WIDTH-1:0] bb,
                                                  input logic [WORD_WIDTH-1:0] nn);
      logic [XW-1:0] t;
      logic [XW-1:0] nx;
      nx = {2'b00, nn};
      t  = {1'b0, r, 1'b0} + (bit_i ? {2'b00, bb} : '0);
      if (t >= nx) t = t - nx;
      if (t >= nx) t = t - nx;
      return t[WORD_WIDTH-1:0];
   endfunction

   // Next-state: load and take the first step on start, then one step per cycle.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      n_d    = n_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = done_q;
      if (start) begin
         a_d    = a << 1;
         b_d    = b;
         n_d    = n;
         r_d    = step('0, a[WORD_WIDTH-1], b, n);
         cnt_d  = CW'(WORD_WIDTH - 1);
         busy_d = (WORD_WIDTH > 1);
         done_d = (WORD_WIDTH == 1);
      end else if (busy_q) begin
         a_d   = a_q << 1;
         r_d   = step(r_q, a_q[WORD_WIDTH-1], b_q, n_q);
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // State registers; reset aborts any multiplication in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         n_q    <= n_d;
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign done   = done_q;
   assign result = r_q;

endmodule

// File: rtl/rsa_modexp.sv
// RSA modular exponentiation: result = msg^exponent mod N.
// Right-to-left square-and-multiply over all WORD_WIDTH exponent bits,
// using two concurrent mod_mult instances (acc*base and base*base).
// Optional macro RSA_MODEXP_RANGE_CHECK_EN: reject N < 2 or msg >= N
// with err = 1 and result = 0 without computing.
module rsa_modexp
   import rsa_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] N,
   input  logic [WORD_WIDTH-1:0] exponent,
   input  logic [WORD_WIDTH-1:0] msg,
   output logic [WORD_WIDTH-1:0] result,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CW = ctr_width(WORD_WIDTH);

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] n_q, n_d, exp_q, exp_d, msg_q, msg_d;
   logic [WORD_WIDTH-1:0] acc_q, acc_d, base_q, base_d, result_q, result_d;
   logic [CW-1:0]         bit_q, bit_d;
   logic                  done_q, done_d, err_q, err_d;
   logic                  mm_start, mul_done, sq_done;
   logic [WORD_WIDTH-1:0] prod, sq;

   // FSM and datapath next-state; multipliers are fed the next acc/base so
   // their first step coincides with the edge that enters MULT.
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      exp_d    = exp_q;
      msg_d    = msg_q;
      acc_d    = acc_q;
      base_d   = base_q;
      bit_d    = bit_q;
      result_d = result_q;
      done_d   = done_q;
      err_d    = err_q;
      mm_start = 1'b0;
      case (state_q)
         IDLE, FINISH: begin
            if (state_q == FINISH) done_d = 1'b1;
            if (start) begin
               n_d     = N;
               exp_d   = exponent;
               msg_d   = msg;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = LOAD;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
               if ((N < WORD_WIDTH'(2)) || (msg >= N)) begin
                  state_d  = FINISH;
                  err_d    = 1'b1;
                  result_d = '0;
               end
`endif
            end
         end
         LOAD: begin
            acc_d    = (n_q == WORD_WIDTH'(1)) ? '0 : WORD_WIDTH'(1);
            base_d   = msg_q;
            bit_d    = '0;
            mm_start = 1'b1;
            state_d  = MULT;
         end
         MULT: begin
            if (mul_done && sq_done) state_d = UPDATE;
         end
         UPDATE: begin
            if (exp_q[0]) acc_d = prod;
            base_d = sq;
            exp_d  = exp_q >> 1;
            bit_d  = bit_q + CW'(1);
            if (bit_q == CW'(WORD_WIDTH - 1)) begin
               state_d  = FINISH;
               result_d = acc_d;
            end else begin
               state_d  = MULT;
               mm_start = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; a start coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         n_q      <= '0;
         exp_q    <= '0;
         msg_q    <= '0;
         acc_q    <= '0;
         base_q   <= '0;
         bit_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         exp_q    <= exp_d;
         msg_q    <= msg_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         bit_q    <= bit_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   mod_mult #(.WORD_WIDTH(WORD_WIDTH)) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mm_start),
      .a      (acc_d),
      .b      (base_d),
      .n      (n_q),
      .done   (mul_done),
      .result (prod)
   );

   mod_mult #(.WORD_WIDTH(WORD_WIDTH)) u_sq (
      .clk    (clk),
      .rst    (rst),
      .start  (mm_start),
      .a      (base_d),
      .b      (base_d),
      .n      (n_q),
      .done   (sq_done),
      .result (sq)
   );

   assign result = result_q;
   assign done   = done_q;
   assign err    = err_q;
   assign busy   = (state_q == LOAD) || (state_q == MULT) || (state_q == UPDATE);

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed scoreboard bench for rsa_modexp (WORD_WIDTH = 32).
// Expected results come from a 64-bit square-and-multiply reference model.
module tb_rsa_modexp;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W * (W + 1) + 2;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] N, exponent, msg, result;
   logic         busy, done, err;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rsa_modexp #(.WORD_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .N        (N),
      .exponent (exponent),
      .msg      (msg),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         e;
      int unsigned  lat;
      bit           chk_res;
   } exp_t;

   exp_t         sb[$];
   int           checks   = 0;
   int           failures = 0;
   int unsigned  t0;
   logic [W-1:0] res_before;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] n, input logic [W-1:0] e,
                                               input logic [W-1:0] m);
      logic [63:0] r, b, nn;
      nn = {32'd0, n};
      r  = 64'd1 % nn;
      b  = {32'd0, m} % nn;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * b) % nn;
         b = (b * b) % nn;
      end
      return r[W-1:0];
   endfunction

   function automatic bit range_bad(input logic [W-1:0] n, input logic [W-1:0] m);
`ifdef RSA_MODEXP_RANGE_CHECK_EN
      return (n < 2) || (m >= n);
`else
      return 1'b0;
`endif
   endfunction

   // Drive one start pulse and record the expectation; returns just after the sampling edge.
   task automatic issue(input logic [W-1:0] n, input logic [W-1:0] e, input logic [W-1:0] m,
                        input bit chk_res);
      exp_t x;
      @(negedge clk);
      N = n; exponent = e; msg = m; start = 1'b1;
      if (range_bad(n, m)) begin
         x.res = '0; x.e = 1'b1; x.lat = 1; x.chk_res = 1'b1;
      end else begin
         x.res = ref_modexp(n, e, m); x.e = 1'b0; x.lat = LAT; x.chk_res = chk_res;
      end
      sb.push_back(x);
      res_before = result;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   // Wait (bounded) for done, optionally re-pulsing start mid-job, then score.
   task automatic finish_job(input string tag, input int repulse_at);
      bit   seen = 1'b0;
      bit   hold_ok = 1'b1;
      exp_t x;
      for (int i = 1; i <= int'(LAT) + 20; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy && (result !== res_before)) hold_ok = 1'b0;
         if (i == repulse_at) begin
            N = 32'd11; exponent = 32'd3; msg = 32'd2; start = 1'b1;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
         x = sb.pop_front();
         chk({tag, "_latency"}, 64'(cyc - t0), 64'(x.lat));
         chk({tag, "_err"}, {63'd0, err}, {63'd0, x.e});
         if (x.chk_res) chk({tag, "_result"}, {32'd0, result}, {32'd0, x.res});
         chk({tag, "_result_hold"}, {63'd0, hold_ok}, 64'd1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; N = '0; exponent = '0; msg = '0;
      repeat (2) @(posedge clk);
      // start coinciding with reset must be ignored
      @(negedge clk);
      N = 32'd3233; exponent = 32'd17; msg = 32'd65; start = 1'b1;
      @(posedge clk); #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_err", {63'd0, err}, 64'd0);
      chk("reset_result", {32'd0, result}, 64'd0);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("rst_start_ignored", {63'd0, busy}, 64'd0);

      // encrypt, then decrypt back-to-back from FINISH
      issue(32'd3233, 32'd17, 32'd65, 1'b1);
      chk("enc_busy", {63'd0, busy}, 64'd1);
      finish_job("enc", 0);
      issue(32'd3233, 32'd2753, 32'd2790, 1'b1);
      chk("b2b_done_drop", {63'd0, done}, 64'd0);
      finish_job("dec", 0);

      // edge operands
      issue(32'd3233, 32'd0, 32'd65, 1'b1);
      finish_job("exp_zero", 0);
      issue(32'd1, 32'd17, 32'd0, 1'b1);
      finish_job("n_one", 0);
      issue(32'd3233, 32'd17, 32'd0, 1'b1);
      finish_job("msg_zero", 0);
      issue(32'hFFFF_FFFB, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      finish_job("wide_n", 0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      finish_job("max_n", 0);

      // start while busy is ignored
      issue(32'd3233, 32'd17, 32'd65, 1'b1);
      finish_job("repulse", 100);

      // reset mid-job, then a fresh job
      issue(32'd3233, 32'd2753, 32'd2790, 1'b1);
      repeat (499) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_result", {32'd0, result}, 64'd0);
      chk("midrst_err", {63'd0, err}, 64'd0);
      void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b0;
      issue(32'd3233, 32'd2753, 32'd2790, 1'b1);
      finish_job("after_rst", 0);

      // msg >= N: rejected with err when range checking is built in
      issue(32'd3233, 32'd17, 32'd3233, 1'b0);
      finish_job("range", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
